// File: rtl/llc_sweep_ctrl.sv
// LLC reset/flush sweep sequencer: drives stall-flag command pulses and walks every set/way.
// Optional LLC_FLUSH_INVALIDATE_EN: flush invalidates every valid line instead of keeping it clean.
`ifndef LLC_SETS
`define LLC_SETS 4
`endif
`ifndef LLC_WAYS
`define LLC_WAYS 2
`endif
`ifndef LLC_TAG_BITS
`define LLC_TAG_BITS 9
`endif

module llc_sweep_ctrl #(
    parameter int unsigned SETS     = `LLC_SETS,
    parameter int unsigned WAYS     = `LLC_WAYS,
    parameter int unsigned SET_BITS = $clog2(SETS),
    parameter int unsigned WAY_BITS = $clog2(WAYS),
    parameter int unsigned TAG_BITS = `LLC_TAG_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rst_start,
    input  logic                         flush_start,
    output logic                         busy,
    output logic                         clr_rst_stall,
    output logic                         set_flush_stall,
    output logic                         clr_flush_stall,
    output logic                         clr_rst_flush_stalled_set,
    output logic                         incr_rst_flush_stalled_set,
    output logic                         rd_req,
    output logic [SET_BITS-1:0]          rd_set,
    output logic [WAY_BITS-1:0]          rd_way,
    input  logic                         rd_valid,
    input  logic                         rd_line_valid,
    input  logic                         rd_dirty,
    input  logic [TAG_BITS-1:0]          rd_tag,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [SET_BITS-1:0]          wr_set,
    output logic [WAY_BITS-1:0]          wr_way,
    output logic                         wr_all_ways,
    output logic                         wr_line_valid,
    output logic                         wr_dirty,
    output logic                         evict_valid,
    input  logic                         evict_ready,
    output logic [TAG_BITS+SET_BITS-1:0] evict_addr
);

    typedef enum logic [2:0] {
        IDLE, RST_WR, FL_RD, FL_WAIT, FL_EVICT, FL_WR, DONE
    } state_t;

    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);
    localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(WAYS - 1);
`ifdef LLC_FLUSH_INVALIDATE_EN
    localparam logic FL_LINE_VALID = 1'b0;
`else
    localparam logic FL_LINE_VALID = 1'b1;
`endif

    state_t                r_state, w_state_nxt;
    logic [SET_BITS-1:0]   r_set, w_set_nxt;
    logic [WAY_BITS-1:0]   r_way, w_way_nxt;
    logic [TAG_BITS-1:0]   r_tag, w_tag_nxt;
    logic                  r_lvalid, w_lvalid_nxt;
    logic                  r_ldirty, w_ldirty_nxt;
    logic                  r_rsp, w_rsp_nxt;
    logic                  r_clr_rst, w_clr_rst;
    logic                  r_set_fl, w_set_fl;
    logic                  r_clr_fl, w_clr_fl;
    logic                  r_clr_rfs, w_clr_rfs;
    logic                  r_incr, w_incr;
    logic                  w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_set     <= '0;
            r_way     <= '0;
            r_tag     <= '0;
            r_lvalid  <= 1'b0;
            r_ldirty  <= 1'b0;
            r_rsp     <= 1'b0;
            r_clr_rst <= 1'b0;
            r_set_fl  <= 1'b0;
            r_clr_fl  <= 1'b0;
            r_clr_rfs <= 1'b0;
            r_incr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_set     <= w_set_nxt;
            r_way     <= w_way_nxt;
            r_tag     <= w_tag_nxt;
            r_lvalid  <= w_lvalid_nxt;
            r_ldirty  <= w_ldirty_nxt;
            r_rsp     <= w_rsp_nxt;
            r_clr_rst <= w_clr_rst;
            r_set_fl  <= w_set_fl;
            r_clr_fl  <= w_clr_fl;
            r_clr_rfs <= w_clr_rfs;
            r_incr    <= w_incr;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_set_nxt    = r_set;
        w_way_nxt    = r_way;
        w_tag_nxt    = r_tag;
        w_lvalid_nxt = r_lvalid;
        w_ldirty_nxt = r_ldirty;
        w_rsp_nxt    = r_rsp;
        w_clr_rst    = 1'b0;
        w_set_fl     = 1'b0;
        w_clr_fl     = 1'b0;
        w_clr_rfs    = 1'b0;
        w_incr       = 1'b0;
        w_adv        = 1'b0;

        if (rst_start && (r_state != IDLE)) begin
            // abort: any sweep restarts as a reset sweep; a flush also drops its stall
            w_state_nxt = RST_WR;
            w_set_nxt   = '0;
            w_way_nxt   = '0;
            w_rsp_nxt   = 1'b0;
            w_clr_rfs   = 1'b1;
            w_clr_fl    = r_state inside {FL_RD, FL_WAIT, FL_EVICT, FL_WR};
        end else begin
            case (r_state)
                IDLE: begin
                    if (rst_start) begin
                        w_state_nxt = RST_WR;
                        w_set_nxt   = '0;
                        w_way_nxt   = '0;
                        w_clr_rfs   = 1'b1;
                    end else if (flush_start) begin
                        w_state_nxt = FL_RD;
                        w_set_nxt   = '0;
                        w_way_nxt   = '0;
                        w_set_fl    = 1'b1;
                        w_clr_rfs   = 1'b1;
                    end
                end
                RST_WR: begin
                    if (wr_ready) begin
                        w_incr = 1'b1;
                        if (r_set == LAST_SET) begin
                            w_clr_rst   = 1'b1;
                            w_state_nxt = DONE;
                        end else begin
                            w_set_nxt = r_set + 1'b1;
                        end
                    end
                end
                FL_RD: w_state_nxt = FL_WAIT;
                FL_WAIT: begin
                    // response is captured first, decided on the following cycle
                    if (!r_rsp) begin
                        if (rd_valid) begin
                            w_tag_nxt    = rd_tag;
                            w_lvalid_nxt = rd_line_valid;
                            w_ldirty_nxt = rd_dirty;
                            w_rsp_nxt    = 1'b1;
                        end
                    end else begin
                        w_rsp_nxt = 1'b0;
                        if (r_lvalid && r_ldirty) begin
                            w_state_nxt = FL_EVICT;
                        end else if (r_lvalid) begin
`ifdef LLC_FLUSH_INVALIDATE_EN
                            w_state_nxt = FL_WR;
`else
                            w_adv = 1'b1;
`endif
                        end else begin
                            w_adv = 1'b1;
                        end
                    end
                end
                FL_EVICT: if (evict_ready) w_state_nxt = FL_WR;
                FL_WR:    if (wr_ready) w_adv = 1'b1;
                DONE:     w_state_nxt = IDLE;
                default:  w_state_nxt = IDLE;
            endcase

            if (w_adv) begin
                w_state_nxt = FL_RD;
                if (r_way == LAST_WAY) begin
                    w_way_nxt = '0;
                    w_incr    = 1'b1;
                    if (r_set == LAST_SET) begin
                        w_clr_fl    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_set_nxt = r_set + 1'b1;
                    end
                end else begin
                    w_way_nxt = r_way + 1'b1;
                end
            end
        end
    end

    assign busy                       = (r_state != IDLE);
    assign clr_rst_stall              = r_clr_rst;
    assign set_flush_stall            = r_set_fl;
    assign clr_flush_stall            = r_clr_fl;
    assign clr_rst_flush_stalled_set  = r_clr_rfs;
    assign incr_rst_flush_stalled_set = r_incr;

    assign rd_req        = (r_state == FL_RD);
    assign rd_set        = r_set;
    assign rd_way        = r_way;

    assign wr_valid      = (r_state == RST_WR) || (r_state == FL_WR);
    assign wr_set        = r_set;
    assign wr_way        = r_way;
    assign wr_all_ways   = (r_state == RST_WR);
    assign wr_line_valid = (r_state == FL_WR) && FL_LINE_VALID;
    assign wr_dirty      = 1'b0;

    assign evict_valid   = (r_state == FL_EVICT);
    assign evict_addr    = {r_tag, r_set};

endmodule

// File: tb/tb_llc_sweep_ctrl.sv
// Self-checking bench for llc_sweep_ctrl: directed sweeps, aborts and randomized flushes vs a line-state model.
module tb_llc_sweep_ctrl;

    localparam int unsigned SETS = 4;
    localparam int unsigned WAYS = 2;
    localparam int unsigned SB   = 2;
    localparam int unsigned WB   = 1;
    localparam int unsigned TW   = 9;
`ifdef LLC_FLUSH_INVALIDATE_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, rst_start, flush_start, busy;
    logic clr_rst_stall, set_flush_stall, clr_flush_stall;
    logic clr_rst_flush_stalled_set, incr_rst_flush_stalled_set;
    logic rd_req, rd_valid, rd_line_valid, rd_dirty;
    logic [SB-1:0] rd_set, wr_set;
    logic [WB-1:0] rd_way, wr_way;
    logic [TW-1:0] rd_tag;
    logic wr_valid, wr_ready, wr_all_ways, wr_line_valid, wr_dirty;
    logic evict_valid, evict_ready;
    logic [TW+SB-1:0] evict_addr;
    logic [5:0] wr_word;

    always #5 clk = ~clk;

    llc_sweep_ctrl #(.SETS(SETS), .WAYS(WAYS), .SET_BITS(SB), .WAY_BITS(WB), .TAG_BITS(TW)) u_dut (
        .clk(clk), .rst(rst), .rst_start(rst_start), .flush_start(flush_start), .busy(busy),
        .clr_rst_stall(clr_rst_stall), .set_flush_stall(set_flush_stall),
        .clr_flush_stall(clr_flush_stall), .clr_rst_flush_stalled_set(clr_rst_flush_stalled_set),
        .incr_rst_flush_stalled_set(incr_rst_flush_stalled_set),
        .rd_req(rd_req), .rd_set(rd_set), .rd_way(rd_way), .rd_valid(rd_valid),
        .rd_line_valid(rd_line_valid), .rd_dirty(rd_dirty), .rd_tag(rd_tag),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_set(wr_set), .wr_way(wr_way),
        .wr_all_ways(wr_all_ways), .wr_line_valid(wr_line_valid), .wr_dirty(wr_dirty),
        .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_addr(evict_addr)
    );

    assign wr_word = {wr_all_ways, wr_set, wr_way, wr_line_valid, wr_dirty};

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // line-state store behind the tag/state RAM port, and its pre-flush snapshot
    bit            mem_v [SETS][WAYS];
    bit            mem_d [SETS][WAYS];
    logic [TW-1:0] mem_t [SETS][WAYS];
    bit            snap_v [SETS][WAYS];
    bit            snap_d [SETS][WAYS];
    logic [TW-1:0] snap_t [SETS][WAYS];

    bit rnd_rdy = 1'b0, ev_block = 1'b0, lat_fixed = 1'b1;
    int rsp_key[$], rsp_cnt[$];
    int rd_q[$], wr_q[$], ev_q[$];
    int n_incr, n_crs, n_sfs, n_cfs, n_crfs, n_busy, ncyc, last_wr_cyc, crs_cyc;
    logic prev_wr_pend = 1'b0, prev_ev_pend = 1'b0;
    logic [5:0] prev_wr_word;
    logic [TW+SB-1:0] prev_ev_addr;

    function automatic int wrw(input bit all, input int s, input int w, input bit lv);
        return (int'(all) << (SB + WB + 2)) | (s << (WB + 2)) | (w << 2) | (int'(lv) << 1);
    endfunction

    task automatic clear_stats();
        rd_q.delete(); wr_q.delete(); ev_q.delete();
        n_incr = 0; n_crs = 0; n_sfs = 0; n_cfs = 0; n_crfs = 0; n_busy = 0;
        last_wr_cyc = -100; crs_cyc = -200;
    endtask

    task automatic take_snap();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                snap_v[s][w] = mem_v[s][w]; snap_d[s][w] = mem_d[s][w]; snap_t[s][w] = mem_t[s][w];
            end
    endtask

    // monitor: sampled mid-cycle, records handshakes and applies writes to the store
    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            if (busy) n_busy++;
            if (incr_rst_flush_stalled_set) n_incr++;
            if (set_flush_stall) n_sfs++;
            if (clr_flush_stall) n_cfs++;
            if (clr_rst_flush_stalled_set) n_crfs++;
            if (clr_rst_stall) begin n_crs++; crs_cyc = ncyc; end
            if (rd_req) begin
                rd_q.push_back(int'({rd_set, rd_way}));
                rsp_key.push_back(int'({rd_set, rd_way}));
                rsp_cnt.push_back(lat_fixed ? 1 : int'($urandom_range(1, 3)));
            end
            if (wr_valid && wr_ready) begin
                wr_q.push_back(int'(wr_word));
                last_wr_cyc = ncyc;
                for (int w = 0; w < WAYS; w++)
                    if (wr_all_ways || (w == int'(wr_way))) begin
                        mem_v[wr_set][w] = wr_line_valid;
                        mem_d[wr_set][w] = wr_dirty;
                    end
            end
            if (evict_valid && evict_ready) ev_q.push_back(int'(evict_addr));
            if (prev_wr_pend && wr_valid) check("wr_stable", wr_word, prev_wr_word);
            if (prev_ev_pend && evict_valid) check("ev_stable", evict_addr, prev_ev_addr);
            prev_wr_pend = wr_valid && !wr_ready;
            prev_wr_word = wr_word;
            prev_ev_pend = evict_valid && !evict_ready;
            prev_ev_addr = evict_addr;
        end
    end

    // responder: ready generation and read data returned L cycles after rd_req
    always @(posedge clk) begin
        int k, s, w;
        #1;
        wr_ready      = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        evict_ready   = ev_block ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
        rd_valid      = 1'b0;
        rd_line_valid = 1'b0;
        rd_dirty      = 1'b0;
        rd_tag        = '0;
        if (rsp_cnt.size() != 0) begin
            rsp_cnt[0] = rsp_cnt[0] - 1;
            if (rsp_cnt[0] <= 0) begin
                k = rsp_key.pop_front();
                void'(rsp_cnt.pop_front());
                s = k >> WB;
                w = k & ((1 << WB) - 1);
                rd_valid      = 1'b1;
                rd_line_valid = mem_v[s][w];
                rd_dirty      = mem_d[s][w];
                rd_tag        = mem_t[s][w];
            end
        end
    end

    task automatic pulse(input bit r, input bit f);
        @(posedge clk); #1;
        rst_start = r; flush_start = f;
        @(posedge clk); #1;
        rst_start = 1'b0; flush_start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int i;
        i = 0;
        @(negedge clk);
        while (busy && i < max) begin @(negedge clk); i++; end
        check("idle_timeout", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic wait_evict(input int max);
        int i;
        i = 0;
        @(negedge clk);
        while (!evict_valid && i < max) begin @(negedge clk); i++; end
        check("evict_seen", evict_valid, 1'b1);
    endtask

    // reference: visit every (set, way) in order; dirty lines evict then write, clean ones
    // are rewritten only when invalidating
    task automatic compare_flush(input string tg);
        int erd[$], ewr[$], eev[$];
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                erd.push_back((s << WB) | w);
                if (snap_v[s][w] && snap_d[s][w]) begin
                    eev.push_back((int'(snap_t[s][w]) << SB) | s);
                    ewr.push_back(wrw(1'b0, s, w, !INV));
                end else if (snap_v[s][w] && INV) begin
                    ewr.push_back(wrw(1'b0, s, w, 1'b0));
                end
            end
        check({tg, "_nrd"}, rd_q.size(), erd.size());
        check({tg, "_nwr"}, wr_q.size(), ewr.size());
        check({tg, "_nev"}, ev_q.size(), eev.size());
        foreach (erd[i]) check({tg, "_rd"}, (i < rd_q.size()) ? rd_q[i] : -1, erd[i]);
        foreach (ewr[i]) check({tg, "_wr"}, (i < wr_q.size()) ? wr_q[i] : -1, ewr[i]);
        foreach (eev[i]) check({tg, "_ev"}, (i < ev_q.size()) ? ev_q[i] : -1, eev[i]);
        check({tg, "_incr"}, n_incr, SETS);
        check({tg, "_pulses"}, {n_sfs[7:0], n_cfs[7:0], n_crfs[7:0], n_crs[7:0]}, 32'h01010100);
    endtask

    initial begin
        int held, nd, nv, sv;
        logic [TW-1:0] t;
        rst = 1'b1; rst_start = 1'b0; flush_start = 1'b0;
        wr_ready = 1'b0; evict_ready = 1'b0;
        rd_valid = 1'b0; rd_line_valid = 1'b0; rd_dirty = 1'b0; rd_tag = '0;
        ncyc = 0;
        clear_stats();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mem_v[s][w] = 1'b0; mem_d[s][w] = 1'b0; mem_t[s][w] = '0;
            end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {clr_rst_stall, set_flush_stall, clr_flush_stall,
                             clr_rst_flush_stalled_set, incr_rst_flush_stalled_set}, 5'b0);
        check("rst_rd", {rd_req, rd_set, rd_way}, '0);
        check("rst_wr", {wr_valid, wr_word}, '0);
        check("rst_ev", {evict_valid, evict_addr}, '0);

        // reset sweep, wr_ready held high
        @(posedge clk); #1;
        clear_stats();
        pulse(1'b1, 1'b0);
        wait_idle(50);
        check("rs_busy_cycles", n_busy, SETS + 1);
        check("rs_nwr", wr_q.size(), SETS);
        for (int i = 0; i < SETS; i++)
            check("rs_wr", (i < wr_q.size()) ? wr_q[i] : -1, wrw(1'b1, i, 0, 1'b0));
        check("rs_incr", n_incr, SETS);
        check("rs_pulses", {n_sfs[7:0], n_cfs[7:0], n_crfs[7:0], n_crs[7:0]}, 32'h00000101);
        check("rs_clr_timing", crs_cyc, last_wr_cyc + 1);

        // flush of an all-invalid cache, read latency 1
        take_snap(); clear_stats();
        pulse(1'b0, 1'b1);
        wait_idle(200);
        compare_flush("fl_inv");
        check("fl_inv_busy_cycles", n_busy, SETS * WAYS * 3 + 1);

        // one dirty line held in eviction, one clean valid line
        mem_v[2][1] = 1'b1; mem_d[2][1] = 1'b1; mem_t[2][1] = 9'h1A5;
        mem_v[1][0] = 1'b1; mem_d[1][0] = 1'b0; mem_t[1][0] = TW'($urandom);
        take_snap(); clear_stats();
        lat_fixed = 1'b0; ev_block = 1'b1;
        pulse(1'b0, 1'b1);
        wait_evict(200);
        check("ev_addr", evict_addr, {9'h1A5, 2'd2});
        held = 0;
        repeat (5) begin
            @(negedge clk);
            if (evict_valid && evict_addr == {9'h1A5, 2'd2}) held++;
        end
        check("ev_hold", held, 5);
        ev_block = 1'b0;
        wait_idle(300);
        compare_flush("fl_dirty");

        // simultaneous start: reset wins
        clear_stats();
        pulse(1'b1, 1'b1);
        wait_idle(50);
        check("both_sfs", n_sfs, 0);
        check("both_nrd", rd_q.size(), 0);
        check("both_nwr", wr_q.size(), SETS);
        check("both_wr0", (wr_q.size() != 0) ? wr_q[0] : -1, wrw(1'b1, 0, 0, 1'b0));
        check("both_crs", n_crs, 1);

        // abort while stuck in eviction at set 3
        t = TW'($urandom);
        mem_v[3][0] = 1'b1; mem_d[3][0] = 1'b1; mem_t[3][0] = t;
        ev_block = 1'b1;
        clear_stats();
        pulse(1'b0, 1'b1);
        wait_evict(300);
        check("ab_ev_addr", evict_addr, {t, 2'd3});
        @(posedge clk); #1;
        clear_stats();
        rst_start = 1'b1;
        @(posedge clk); #1;
        rst_start = 1'b0;
        @(negedge clk);
        check("ab_ev_drop", evict_valid, 1'b0);
        check("ab_clr_pair", {clr_flush_stall, clr_rst_flush_stalled_set}, 2'b11);
        check("ab_restart", {wr_valid, wr_all_ways, wr_set}, {1'b1, 1'b1, 2'd0});
        ev_block = 1'b0;
        wait_idle(50);
        check("ab_pulses", {n_sfs[7:0], n_cfs[7:0], n_crfs[7:0], n_crs[7:0]}, 32'h00010101);
        check("ab_nev", ev_q.size(), 0);
        check("ab_nwr", wr_q.size(), SETS);
        check("ab_wr0", (wr_q.size() != 0) ? wr_q[0] : -1, wrw(1'b1, 0, 0, 1'b0));
        check("ab_incr", n_incr, SETS);

        // randomized contents, latencies and back-pressure
        rnd_rdy = 1'b1;
        for (int it = 0; it < 6; it++) begin
            sv = 0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    mem_v[s][w] = ($urandom_range(0, 1) != 0);
                    mem_d[s][w] = mem_v[s][w] && ($urandom_range(0, 1) != 0);
                    mem_t[s][w] = TW'($urandom);
                    if (mem_v[s][w]) sv++;
                end
            take_snap(); clear_stats();
            pulse(1'b0, 1'b1);
            wait_idle(3000);
            compare_flush("fl_rand");
            nd = 0; nv = 0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    if (mem_d[s][w]) nd++;
                    if (mem_v[s][w]) nv++;
                end
            check("fl_rand_dirty_left", nd, 0);
            check("fl_rand_valid_left", nv, INV ? 0 : sv);
        end

        clear_stats();
        pulse(1'b1, 1'b0);
        wait_idle(500);
        check("rs_rand_nwr", wr_q.size(), SETS);
        check("rs_rand_incr", n_incr, SETS);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/llc_sweep_ctrl.md
# llc_sweep_ctrl

Sequencer on the command side of the LLC control-register bank. It generates the set/clear/increment pulses that drive `rst_stall`, `flush_stall` and `rst_flush_stalled_set`, and performs the sweeps those flags announce. A reset sweep writes invalid state to every set. A flush sweep reads every (set, way), writes back dirty lines through an eviction handshake, then rewrites line state. It sits beside the register bank and arbitrates the tag/state RAM port while a stall flag is high.

## Interface
- `SETS`, default `LLC_SETS`: number of sets; power of two, at least 2.
- `WAYS`, default `LLC_WAYS`: number of ways; power of two, at least 2.
- `SET_BITS`, default `$clog2(SETS)`: set index width.
- `WAY_BITS`, default `$clog2(WAYS)`: way index width.
- `TAG_BITS`, default `LLC_TAG_BITS`: tag width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: **one clock; reset is synchronous and active-high.**
- `rst_start` in 1: pulse; begin reset sweep.
- `flush_start` in 1: pulse; begin flush sweep.
- `busy` out 1: high when the FSM is not in IDLE.
- `clr_rst_stall` out 1: one-cycle pulse at the end of the reset sweep.
- `set_flush_stall` out 1: one-cycle pulse when a flush is accepted.
- `clr_flush_stall` out 1: one-cycle pulse at the end of the flush sweep.
- `clr_rst_flush_stalled_set` out 1: one-cycle pulse when either sweep is accepted.
- `incr_rst_flush_stalled_set` out 1: one-cycle pulse per completed set.
- `rd_req` out 1, `rd_set` out SET_BITS, `rd_way` out WAY_BITS: state read request (pulse).
- `rd_valid` in 1, `rd_line_valid` in 1, `rd_dirty` in 1, `rd_tag` in TAG_BITS: read response, arbitrary latency of 1 or more cycles.
- `wr_valid` out 1, `wr_ready` in 1, `wr_set` out SET_BITS, `wr_way` out WAY_BITS, `wr_all_ways` out 1, `wr_line_valid` out 1, `wr_dirty` out 1: state write.
- `evict_valid` out 1, `evict_ready` in 1, `evict_addr` out TAG_BITS+SET_BITS: writeback request; `evict_addr` = {tag, set}.

## Operation
- States: IDLE, RST_WR, FL_RD, FL_WAIT, FL_EVICT, FL_WR, DONE.
- **IDLE**
  - `rst_start` → RST_WR, with set = 0 and `clr_rst_flush_stalled_set` pulsed.
  - `flush_start` → FL_RD, with set = 0, way = 0, and `set_flush_stall` plus `clr_rst_flush_stalled_set` pulsed.
  - Both asserted in the same cycle: reset wins; the flush request is dropped.
- **RST_WR**
  - Drives `wr_valid` = 1, `wr_all_ways` = 1, `wr_line_valid` = 0, `wr_dirty` = 0, `wr_set` = set.
  - On `wr_ready`: pulse `incr_rst_flush_stalled_set`.
  - If set == SETS-1: pulse `clr_rst_stall` and go to DONE. Otherwise set += 1.
- **FL_RD**
  - Pulse `rd_req` with the current set/way, then go to FL_WAIT.
- **FL_WAIT**
  - On `rd_valid`, latch tag, valid and dirty.
  - valid & dirty → FL_EVICT.
  - valid & clean → FL_WR if the config macro is defined, otherwise advance.
  - invalid → advance.
- **FL_EVICT**
  - Holds `evict_valid` with a stable `evict_addr` until `evict_ready`, then goes to FL_WR.
- **FL_WR**
  - Drives `wr_all_ways` = 0 and `wr_dirty` = 0.
  - `wr_line_valid` per the Configuration section.
  - On `wr_ready`: advance.
- **Advance**
  - way += 1 and return to FL_RD.
  - When way == WAYS-1: way wraps to 0 and `incr_rst_flush_stalled_set` is pulsed. If set == SETS-1, pulse `clr_flush_stall` and go to DONE; otherwise set += 1 and return to FL_RD.
- **DONE**
  - Returns to IDLE after one cycle.
- Counters are unsigned and wrap naturally; there is no terminal overflow.
- `rst_start` in any non-IDLE state aborts the sweep in progress. The FSM restarts in RST_WR with set = 0 and pulses `clr_rst_flush_stalled_set`. An aborted flush also pulses `clr_flush_stall` in that same cycle.
- `flush_start` while `busy` is ignored.
- An aborted FL_EVICT drops `evict_valid` without waiting for `evict_ready`.

## Timing
- Reset values: FSM = IDLE, set = 0, way = 0, and every output = 0.
- Command pulses are registered and last exactly one cycle.
- Reset sweep with `wr_ready` held high: SETS + 2 cycles from `rst_start` to IDLE.
- `clr_rst_stall` is asserted in the cycle after the final write handshake.
- Flush cost per way:
  - Invalid line: 2 + L cycles, where L is the read latency.
  - Dirty line: add the eviction handshake plus at least 1 write cycle.
- `evict_valid`, `evict_addr`, `wr_*` and `rd_set/rd_way` stay stable while their handshake is pending.
- A write or eviction completes only in a cycle where valid & ready are both high.
- `rd_valid` arriving outside FL_WAIT is ignored.

## Configuration
- `LLC_FLUSH_INVALIDATE_EN` defined:
  - Every valid line visited is rewritten with `wr_line_valid` = 0.
  - Clean valid lines also take FL_WR.
- Undefined:
  - Only dirty lines are rewritten, with `wr_line_valid` = 1 and `wr_dirty` = 0 (written back and kept clean).
  - Clean and invalid lines are skipped without a write.

## Test plan
- SETS=4, `wr_ready`=1, pulse `rst_start`:
  - `wr_set` goes 0,1,2,3 on consecutive cycles with `wr_all_ways`=1.
  - 4 `incr_rst_flush_stalled_set` pulses, one `clr_rst_stall` pulse, IDLE after 6 cycles.
- SETS=4, WAYS=2, all lines invalid, L=1, `flush_start`:
  - `set_flush_stall` pulse, 8 `rd_req`, no `evict_valid`, 4 incr pulses, `clr_flush_stall` pulse.
- Set 2 way 1 dirty with tag 0x1A5:
  - `evict_addr` = {0x1A5, 2'd2}, held for 5 cycles while `evict_ready` is held low.
  - Then one write to (2,1) with `wr_dirty`=0.
- Set 1 way 0 valid and clean:
  - With the macro: one write with `wr_line_valid`=0.
  - Without it: no write at all.
- `rst_start` and `flush_start` in the same cycle: reset sweep only, no `set_flush_stall`.
- `rst_start` during a flush stuck in FL_EVICT at set 3:
  - `evict_valid` drops next cycle.
  - `clr_flush_stall` and `clr_rst_flush_stalled_set` pulse together.
  - Reset sweep restarts at set 0.
